// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM encoding, default addresses and PC target helpers.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetchState_t;

    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0040_0180;
    localparam logic [31:0] PC_STEP             = 32'd4;

    // Word-aligned signed branch displacement.
    function automatic logic [31:0] branchOffset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Region-relative jump: keeps the 256 MB segment of the sequential PC.
    function automatic logic [31:0] jumpTarget(input logic [31:0] pcPlus4,
                                               input logic [25:0] index);
        return {pcPlus4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational next-PC selection for the fetch unit (module next_pc_calc).
// Honours FETCH_INVOP_TRAP_EN: when defined, invOpcode redirects to TRAP_VECTOR.
module next_pc_calc
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        isJmp,
    input  logic        isBeq,
    input  logic        isBne,
    input  logic        invOpcode,
    input  logic        zero,
    output logic [31:0] next_pc
);

    logic        branchTaken;
    logic [31:0] jumpAddr;
    logic [31:0] branchAddr;
    logic [5:0]  unusedOpcField;

    assign unusedOpcField = instr[31:26];
    assign branchTaken    = (isBeq & zero) | (isBne & ~zero);
    assign jumpAddr       = jumpTarget(pc_plus4, instr[25:0]);
    assign branchAddr     = pc_plus4 + branchOffset(instr[15:0]);

`ifdef FETCH_INVOP_TRAP_EN
    always_comb begin
        next_pc = pc_plus4;
        if (invOpcode) begin
            next_pc = TRAP_VECTOR;
        end else if (isJmp) begin
            next_pc = jumpAddr;
        end else if (branchTaken) begin
            next_pc = branchAddr;
        end
    end
`else
    // Trap path compiled out: opcode check result and vector are deliberately dropped.
    logic [32:0] unusedTrapPath;
    assign unusedTrapPath = {invOpcode, TRAP_VECTOR};

    always_comb begin
        next_pc = pc_plus4;
        if (isJmp) begin
            next_pc = jumpAddr;
        end else if (branchTaken) begin
            next_pc = branchAddr;
        end
    end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE -> FETCH (wait on imem_ready) -> EXEC (hold on stall).
// Optional invalid-opcode trap redirect is built only when FETCH_INVOP_TRAP_EN is defined.
//
// state | meaning
// IDLE  | post-reset bubble, no request
// FETCH | imem_req high at pc, waiting for imem_ready
// EXEC  | instr valid for decode/execute, advance pc when stall drops
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opc,
    output logic [5:0]  func,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        isJmp,
    input  logic        isBeq,
    input  logic        isBne,
    input  logic        invOpcode,
    input  logic        zero,
    input  logic        stall,
    output logic        trap
);

    fetchState_t state;
    fetchState_t nextState;
    logic [31:0] nextPc;
    logic        execAdvance;
    logic        fetchDone;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        execAdvance = 1'b0;
        fetchDone   = 1'b0;
        case (state)
            IDLE: begin
                nextState = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    fetchDone = 1'b1;
                    nextState = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    execAdvance = 1'b1;
                    nextState   = FETCH;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            if (fetchDone) begin
                instr <= imem_rdata;
            end
            if (execAdvance) begin
                pc <= nextPc;
            end
        end
    end

    assign imem_addr = pc;
    assign pc_plus4  = pc + PC_STEP;
    assign opc       = instr[31:26];
    assign func      = instr[5:0];

    next_pc_calc #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_nextPc (
        .pc_plus4  (pc_plus4),
        .instr     (instr),
        .isJmp     (isJmp),
        .isBeq     (isBeq),
        .isBne     (isBne),
        .invOpcode (invOpcode),
        .zero      (zero),
        .next_pc   (nextPc)
    );

`ifdef FETCH_INVOP_TRAP_EN
    // Pulse lines up with the first FETCH cycle at the trap vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap <= 1'b0;
        end else begin
            trap <= execAdvance & invOpcode;
        end
    end
`else
    assign trap = 1'b0;
`endif

endmodule
